// File: rtl/riscvsoc_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between the core data port (m0) and the fetch port (m1).
// An in-order owner FIFO steers each read response back to the master that issued the read.
module riscvsoc_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wmask,
  output logic                  m0_ack,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wmask,
  output logic                  m1_ack,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  err
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  typedef enum logic {FAV_M0 = 1'b0, FAV_M1 = 1'b1} rr_t;

  rr_t              rr_q, rr_d;
  logic [MAX_OUT-1:0] owner_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic pop, can_accept, elig0, elig1, grant1, accept, push, head;

  // A pop in the same cycle frees a slot, so a full FIFO can still admit a read.
  always_comb begin
    pop        = mem_rvalid & (cnt_q != '0);
    can_accept = (cnt_q < MAX_CNT) | pop;
    elig0      = m0_req & (m0_we | can_accept);
    elig1      = m1_req & (m1_we | can_accept);
    grant1     = elig1 & (~elig0 | (rr_q == FAV_M1));
    head       = owner_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= FAV_M0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Pointer only moves on an accepted transfer, so a mem_ready stall keeps the grant.
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = grant1 ? FAV_M0 : FAV_M1;
    end
  end

  always_comb begin
    mem_req   = elig0 | elig1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (mem_req) begin
      if (grant1) begin
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wmask = m1_wmask;
      end else begin
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wmask = m0_wmask;
      end
    end
    accept    = mem_req & mem_ready;
    push      = accept & ~mem_we;
    m0_ack    = accept & ~grant1;
    m1_ack    = accept & grant1;
    m0_rvalid = pop & ~head;
    m1_rvalid = pop & head;
    m0_rdata  = mem_rdata;
    m1_rdata  = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (mem_rvalid & (cnt_q == '0)) err_q <= 1'b1;
    end
  end

  // Owner slots are plain storage; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) owner_q[wr_ptr_q] <= grant1;
  end

  assign err = err_q;

endmodule

// File: tb/tb_riscvsoc_mem_arbiter.sv
// Bench for riscvsoc_mem_arbiter: directed scenarios plus random traffic, all compared
// against a queue-based reference model of the arbitration and response routing rules.
module tb_riscvsoc_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;
  localparam int MW      = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_we, m0_ack, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic [MW-1:0]     m0_wmask;
  logic              m1_req, m1_we, m1_ack, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [MW-1:0]     m1_wmask;
  logic              mem_req, mem_we, mem_ready, mem_rvalid, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0]     mem_wmask;

  riscvsoc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int owner_q[$];
  int fav;
  bit err_m;
  int cur_win, cur_cnt;
  bit cur_acc, cur_pop;
  bit last_ack0, last_ack1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  // Compare all DUT outputs against the model on the falling edge.
  task automatic eval();
    bit e0, e1, canacc;
    int head;
    @(negedge clk);
    cur_cnt = owner_q.size();
    cur_pop = mem_rvalid && cur_cnt > 0;
    canacc  = (cur_cnt < MAX_OUT) || cur_pop;
    e0 = m0_req && (m0_we || canacc);
    e1 = m1_req && (m1_we || canacc);
    if (e0 && e1)  cur_win = fav;
    else if (e0)   cur_win = 0;
    else if (e1)   cur_win = 1;
    else           cur_win = -1;
    cur_acc = (cur_win >= 0) && mem_ready;
    head = (cur_cnt > 0) ? owner_q[0] : -1;
    check("mem_req", mem_req, 64'(cur_win >= 0));
    if (cur_win == 0) begin
      check("mem_we", mem_we, m0_we);
      check("mem_addr", mem_addr, m0_addr);
      check("mem_wdata", mem_wdata, m0_wdata);
      check("mem_wmask", mem_wmask, m0_wmask);
    end else if (cur_win == 1) begin
      check("mem_we", mem_we, m1_we);
      check("mem_addr", mem_addr, m1_addr);
      check("mem_wdata", mem_wdata, m1_wdata);
      check("mem_wmask", mem_wmask, m1_wmask);
    end else begin
      check("mem_idle", {mem_we, mem_addr, mem_wmask}, 64'd0);
      check("mem_wdata_idle", mem_wdata, 64'd0);
    end
    check("m0_ack", m0_ack, 64'(cur_acc && cur_win == 0));
    check("m1_ack", m1_ack, 64'(cur_acc && cur_win == 1));
    check("m0_rvalid", m0_rvalid, 64'(cur_pop && head == 0));
    check("m1_rvalid", m1_rvalid, 64'(cur_pop && head == 1));
    if (cur_pop && head == 0) check("m0_rdata", m0_rdata, mem_rdata);
    if (cur_pop && head == 1) check("m1_rdata", m1_rdata, mem_rdata);
    check("err", err, err_m);
    last_ack0 = cur_acc && cur_win == 0;
    last_ack1 = cur_acc && cur_win == 1;
  endtask

  // Advance the model across the rising edge with the inputs of this cycle.
  task automatic commit();
    bit we_w;
    @(posedge clk);
    if (reset) begin
      owner_q.delete();
      fav = 0;
      err_m = 1'b0;
    end else begin
      we_w = (cur_win == 1) ? m1_we : m0_we;
      if (mem_rvalid && cur_cnt == 0) err_m = 1'b1;
      if (cur_pop) void'(owner_q.pop_front());
      if (cur_acc && !we_w) owner_q.push_back(cur_win);
      if (cur_acc) fav = 1 - cur_win;
    end
    #1;
  endtask

  task automatic step();
    eval();
    commit();
  endtask

  task automatic reset_cycle();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  bit pend0, pend1;

  initial begin
    idle();
    fav = 0; err_m = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // reset state: idle outputs all zero
    step();

    // single read by m0, response two cycles later
    m0_req = 1'b1; m0_addr = 32'h100; mem_ready = 1'b1;
    eval();
    check("t1_ack", m0_ack, 1);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_we", mem_we, 0);
    commit();
    idle();
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    eval();
    check("t1_m0_rvalid", m0_rvalid, 1);
    check("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_m1_rvalid", m1_rvalid, 0);
    commit();

    // both masters read continuously: strict alternation and in-order routing
    reset_cycle();
    for (int i = 0; i < 8; i++) begin
      idle();
      mem_ready = 1'b1;
      if (i < 6) begin
        m0_req = 1'b1; m0_addr = 32'h200;
        m1_req = 1'b1; m1_addr = 32'h300;
      end
      if (i >= 2) begin
        mem_rvalid = 1'b1; mem_rdata = 32'(i - 1);
      end
      eval();
      if (i < 6) begin
        check("t2_grant_m1", m1_ack, 64'(i % 2));
        check("t2_addr", mem_addr, (i % 2) ? 32'h300 : 32'h200);
      end
      if (i >= 2) begin
        check("t2_route_m0", m0_rvalid, 64'((i - 2) % 2 == 0));
        check("t2_route_m1", m1_rvalid, 64'((i - 2) % 2 == 1));
      end
      commit();
    end

    // FIFO full: reads blocked, writes pass, a same-cycle response frees a slot
    reset_cycle();
    for (int i = 0; i < 4; i++) begin
      idle();
      m1_req = 1'b1; m1_addr = 32'h1000 + 32'(i); mem_ready = 1'b1;
      step();
    end
    idle();
    m1_req = 1'b1; m1_addr = 32'h1004; mem_ready = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h80; m0_wdata = 32'h55AA; m0_wmask = 4'hF;
    eval();
    check("t3_m1_blocked", m1_ack, 0);
    check("t3_m0_write", m0_ack, 1);
    commit();
    m0_req = 1'b0; m0_we = 1'b0;
    eval();
    check("t3_mem_req_full", mem_req, 0);
    commit();
    mem_rvalid = 1'b1; mem_rdata = 32'h11;
    eval();
    check("t3_ack_on_pop", m1_ack, 1);
    check("t3_rvalid", m1_rvalid, 1);
    commit();

    // mem_ready stall with pointer on m1
    reset_cycle();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; mem_ready = 1'b1;
    step();
    m0_addr = 32'h400; m1_req = 1'b1; m1_addr = 32'h500; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eval();
      check("t4_stall_addr", mem_addr, 32'h500);
      check("t4_stall_ack", {m0_ack, m1_ack}, 0);
      commit();
    end
    mem_ready = 1'b1;
    eval();
    check("t4_m1_ack", m1_ack, 1);
    commit();
    m1_addr = 32'h504;
    eval();
    check("t4_m0_next", m0_ack, 1);
    commit();

    // spurious response sets sticky err
    reset_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    eval();
    check("t5_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
    commit();
    idle();
    eval();
    check("t5_err_set", err, 1);
    commit();
    step();
    reset_cycle();
    eval();
    check("t5_err_clr", err, 0);
    commit();

    // reset with reads outstanding: later responses are spurious
    for (int i = 0; i < 2; i++) begin
      idle();
      m0_req = 1'b1; m0_addr = 32'h600 + 32'(4 * i); mem_ready = 1'b1;
      step();
    end
    reset_cycle();
    for (int i = 0; i < 2; i++) begin
      idle();
      mem_rvalid = 1'b1; mem_rdata = 32'(i);
      eval();
      check("t6_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
      commit();
    end
    idle();
    eval();
    check("t6_err", err, 1);
    commit();

    // random traffic with held requests, stalls, responses and occasional resets
    reset_cycle();
    pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (last_ack0) pend0 = 1'b0;
      if (last_ack1) pend1 = 1'b0;
      reset = 1'b0;
      if ($urandom_range(0, 99) == 0) begin
        idle();
        reset = 1'b1;
        pend0 = 1'b0; pend1 = 1'b0;
      end else begin
        if (!pend0) begin
          m0_req = ($urandom_range(0, 2) != 0);
          m0_we = ($urandom_range(0, 3) == 0);
          m0_addr = $urandom; m0_wdata = $urandom; m0_wmask = MW'($urandom);
          pend0 = m0_req;
        end
        if (!pend1) begin
          m1_req = ($urandom_range(0, 2) != 0);
          m1_we = ($urandom_range(0, 5) == 0);
          m1_addr = $urandom; m1_wdata = $urandom; m1_wmask = MW'($urandom);
          pend1 = m1_req;
        end
        mem_ready = ($urandom_range(0, 3) != 0);
      end
      if (owner_q.size() > 0) mem_rvalid = ($urandom_range(0, 2) == 0);
      else mem_rvalid = ($urandom_range(0, 199) == 0);
      mem_rdata = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/riscvsoc_mem_arbiter.md
Name: riscvsoc_mem_arbiter

Overview:
- Shares the single SoC memory port between the core's data port (master 0) and instruction-fetch port (master 1).
- Arbitrates round-robin and forwards the winning request to memory.
- Tracks outstanding reads in an in-order owner FIFO and routes each read response back to the master that issued it.
- Sits between the RISC-V core and the on-chip memory/bus inside riscvsoc.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-mask width is DATA_W/8.
- MAX_OUT, 4, maximum outstanding reads; power of two, range 2..16.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  data-port request valid
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  address
- m0_wdata  in  DATA_W  write data
- m0_wmask  in  DATA_W/8  byte enables
- m0_ack  out  1  request accepted this cycle
- m0_rvalid  out  1  read data valid
- m0_rdata  out  DATA_W  read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_wmask, m1_ack, m1_rvalid, m1_rdata: same as m0_*, for instruction fetch
- mem_req  out  1  request to memory
- mem_we  out  1  write select
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_wmask  out  DATA_W/8  byte enables
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read response valid; responses arrive in issue order
- mem_rdata  in  DATA_W  read response data
- err  out  1  sticky: response received with no outstanding read

Behaviour:
- Reset state:
  - round-robin pointer favours m0
  - owner FIFO empty (count 0, read/write pointers 0)
  - err = 0
  - All outputs are combinational functions of state and inputs; with all reqs low, all outputs are 0.
- Master handshake:
  - A master asserts req and holds req, we, addr, wdata and wmask stable until it sees ack.
  - The transfer completes in the cycle where ack = 1.
- Eligibility:
  - A master is eligible when req = 1 and either we = 1, or the FIFO can accept an entry.
  - The FIFO can accept when count < MAX_OUT, or when count == MAX_OUT and a response is popped in the same cycle.
- Grant (combinational, zero-cycle):
  - Only one master eligible: it wins.
  - Both eligible: the pointer side wins.
  - Neither eligible: mem_req = 0.
- Memory side:
  - mem_* carry the winner's fields; mem_req = 1 whenever there is a winner.
  - winner_ack = mem_req & mem_ready; the loser's ack = 0.
  - Memory accepting or stalling on mem_ready does not change the grant while inputs are held.
- Pointer update:
  - On an accepted transfer, the pointer moves to the other master.
  - Otherwise it is unchanged, so there is no grant loss during a mem_ready stall.
- Owner FIFO:
  - On an accepted read, push the owner id (0/1).
  - On mem_rvalid with count > 0, pop. Routing is combinational in the same cycle: the owner sees rvalid = 1 and rdata = mem_rdata; the other master sees rvalid = 0.
  - rdata of a non-owning master is don't-care; drive mem_rdata.
  - Writes never push and never receive rvalid.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo MAX_OUT.
- Spurious response (mem_rvalid with count == 0): no rvalid to any master, no pop, err set to 1 until reset.
- Reset mid-operation:
  - The FIFO is flushed and the pointer returns to m0.
  - Responses that arrive after reset for pre-reset reads count as spurious and set err.
- Starvation: with both masters continuously eligible and mem_ready = 1, grants alternate strictly each cycle.

Test Plan:
- Reset, then m0 read A=0x100 with mem_ready = 1 -> m0_ack in the same cycle, mem_addr = 0x100, mem_we = 0. mem_rvalid two cycles later with 0xDEADBEEF -> m0_rvalid = 1, m0_rdata = 0xDEADBEEF, m1_rvalid = 0.
- m0 and m1 both issue reads continuously for 6 cycles with mem_ready = 1 -> grant order m0, m1, m0, m1, m0, m1. Responses 1..6 returned in order route to m0, m1, m0, m1, m0, m1.
- MAX_OUT = 4: m1 issues 4 reads with no responses -> 5th read gets no ack and mem_req = 0. A concurrent m0 write is still acked. A response arriving in the same cycle as the 5th read -> the 5th read is acked in that cycle.
- mem_ready held low for 3 cycles while both masters request, pointer on m1 -> m1 fields stay on mem_* for all 3 cycles. m1 is acked when mem_ready rises, and m0 wins the next cycle.
- mem_rvalid with an empty FIFO -> no master rvalid, err = 1 and held. reset -> err = 0.
- Reset asserted with 2 reads outstanding -> count returns to 0. Two subsequent mem_rvalid pulses -> no master rvalid, err = 1.
